// File: rtl/mem_fill_arbiter.sv
// Shared memory port arbiter for I/D cache misses: 8-word pipelined block fills
// and single-word D-side write-through, with round-robin tie-breaking.
module mem_fill_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_done,
    output logic        d_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t               state_q, state_d;
    logic                 own_d_q, own_d_d;    // 1: current fill belongs to D
    logic                 last_d_q, last_d_d;  // 1: D was granted last
    logic [15:0]          addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [3:0]           issue_q, issue_d;
    logic [2:0]           ret_q, ret_d;
    logic [LATENCY-1:0]   vld_q, vld_d;
    logic                 issue, ret, gnt_d;

    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        issue_d   = issue_q;
        ret_d     = ret_q;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0;
        mem_wdata = 16'h0;
        fill_data = mem_rdata;
        fill_word = 3'd0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        busy      = (state_q != IDLE);
        gnt_d     = d_req && (!i_req || !last_d_q);
        issue     = (state_q == FILL) && !issue_q[3];
        ret       = (state_q == FILL) && vld_q[LATENCY-1];
        // A return emerges exactly LATENCY cycles after its issue.
        vld_d     = (vld_q << 1) | LATENCY'(issue);

        case (state_q)
            IDLE: begin
                issue_d = 4'd0;
                ret_d   = 3'd0;
                if (gnt_d) begin
                    last_d_d = 1'b1;
                    own_d_d  = 1'b1;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    state_d  = d_wr ? WRITE : FILL;
                end else if (i_req) begin
                    last_d_d = 1'b0;
                    own_d_d  = 1'b0;
                    addr_d   = i_addr;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (issue) begin
                    mem_en   = 1'b1;
                    mem_addr = {addr_q[15:4], issue_q[2:0], 1'b0};
                    issue_d  = issue_q + 4'd1;
                end
                if (ret) begin
                    fill_word = ret_q;
                    i_fill_we = !own_d_q;
                    d_fill_we = own_d_q;
                    ret_d     = ret_q + 3'd1;
                    if (ret_q == 3'd7) begin
                        i_done  = !own_d_q;
                        d_done  = own_d_q;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_done    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            own_d_q  <= 1'b0;
            last_d_q <= 1'b0;
            addr_q   <= 16'h0;
            wdata_q  <= 16'h0;
            issue_q  <= 4'd0;
            ret_q    <= 3'd0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter: stimulus pushes per-cycle expected
// port activity, a negedge monitor pops and compares whenever the DUT is active.
module tb_mem_fill_arbiter;
    localparam int LAT = 4;

    logic        clk = 0, rst_n = 0;
    logic        i_req = 0, d_req = 0, d_wr = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic        mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_word;

    mem_fill_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .i_done(i_done),
        .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: returns f(addr) LATENCY cycles after the address is presented,
    // and keeps streaming regardless of reset.
    function automatic logic [15:0] f(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction
    logic [15:0] cur_addr = 0;
    logic [15:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = 0;
    always @(negedge clk) cur_addr <= mem_addr;
    always @(posedge clk) begin
        pipe[0] <= cur_addr;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = f(pipe[LAT-1]);

    typedef struct packed {
        logic [15:0] cyc;
        logic        en, wr;
        logic [15:0] addr, wdata;
        logic        iwe, dwe;
        logic [2:0]  word;
        logic [15:0] data;
        logic        idone, ddone, busy;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected per-cycle activity of a fill granted in cycle g; cycles >= cut are dropped.
    task automatic push_fill(input bit own_d, input int unsigned g, input logic [11:0] blk,
                             input int unsigned cut);
        ev_t e;
        int  k, r;
        for (int unsigned t = g + 1; t <= g + 8 + LAT; t++) begin
            if (t < cut) begin
                e = '0;
                e.cyc  = 16'(t);
                e.busy = 1'b1;
                k = int'(t - g) - 1;
                r = k - LAT;
                if (k < 8) begin
                    e.en   = 1'b1;
                    e.addr = {blk, 3'(k), 1'b0};
                end
                if (r >= 0) begin
                    e.iwe  = !own_d;
                    e.dwe  = own_d;
                    e.word = 3'(r);
                    e.data = f({blk, 3'(r), 1'b0});
                    if (r == 7) begin
                        e.idone = !own_d;
                        e.ddone = own_d;
                    end
                end
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t a, e;
        if (rst_n && (mem_en || i_fill_we || d_fill_we || i_done || d_done || busy)) begin
            a = '0;
            a.cyc = 16'(cyc); a.en = mem_en; a.wr = mem_wr; a.addr = mem_addr;
            a.wdata = mem_wdata; a.iwe = i_fill_we; a.dwe = d_fill_we; a.word = fill_word;
            a.data = (i_fill_we || d_fill_we) ? fill_data : 16'h0;
            a.idone = i_done; a.ddone = d_done; a.busy = busy;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_activity: got %h expected none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_cycle%0d: got %h expected %h", e.cyc, a, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {mem_en, mem_wr, mem_addr, mem_wdata, fill_word, i_fill_we,
                   d_fill_we, i_done, d_done, busy}, 64'h0);
    endtask

    int unsigned g;
    ev_t w;

    initial begin
        tick(); tick();
        chk_all_zero("reset_outputs");
        chk("reset_fill_data", fill_data, mem_rdata);
        rst_n = 1;
        tick(); tick();

        // Tie after reset: D first, then I, then D again on the next tie.
        g = cyc;
        i_req = 1; i_addr = 16'h1234; d_req = 1; d_wr = 0; d_addr = 16'h5670;
        push_fill(1, g, 12'h567, '1);
        push_fill(0, g + 9 + LAT, 12'h123, '1);
        tick(); d_req = 0;
        wait_until(g + 10 + LAT); i_req = 0;
        wait_until(g + 18 + 2*LAT);
        chk("tie_idle_gap_busy", busy, 0);
        g = cyc;
        i_req = 1; d_req = 1; d_addr = 16'h89A0;
        push_fill(1, g, 12'h89A, '1);
        tick(); i_req = 0; d_req = 0;
        wait_until(g + 12 + LAT);

        // Single I fill at 0x1234.
        g = cyc;
        i_req = 1; i_addr = 16'h1234;
        push_fill(0, g, 12'h123, '1);
        tick(); i_req = 0;
        wait_until(g + 9 + LAT);
        chk("fill_end_busy", busy, 0);
        tick(); tick();

        // D write-through.
        g = cyc;
        d_req = 1; d_wr = 1; d_addr = 16'h00A4; d_wdata = 16'hBEEF;
        w = '0; w.cyc = 16'(g + 1); w.en = 1; w.wr = 1; w.addr = 16'h00A4;
        w.wdata = 16'hBEEF; w.ddone = 1; w.busy = 1;
        exp_q.push_back(w);
        tick(); d_req = 0;
        tick(); d_wr = 0; d_wdata = 0;
        chk("write_end_busy", busy, 0);
        tick();

        // D read arrives mid I fill; served right after i_done.
        g = cyc;
        i_req = 1; i_addr = 16'h2220;
        push_fill(0, g, 12'h222, '1);
        push_fill(1, g + 9 + LAT, 12'h333, '1);
        tick(); i_req = 0;
        wait_until(g + 3); d_req = 1; d_addr = 16'h3330;
        wait_until(g + 10 + LAT); d_req = 0;
        wait_until(g + 20 + 2*LAT);

        // Address change during a fill must not move the block.
        g = cyc;
        i_req = 1; i_addr = 16'h4440;
        push_fill(0, g, 12'h444, '1);
        tick(); i_req = 0;
        wait_until(g + 3); i_addr = 16'hFFF0;
        wait_until(g + 11 + LAT);

        // Reset during the 3rd return cycle abandons the fill.
        g = cyc;
        d_req = 1; d_addr = 16'h7770;
        push_fill(1, g, 12'h777, g + 3 + LAT);
        tick(); d_req = 0;
        wait_until(g + 3 + LAT);
        rst_n = 0;
        #1;
        chk_all_zero("reset_mid_fill");
        tick(); rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            chk("post_reset_quiet", {busy, i_fill_we, d_fill_we, i_done, d_done}, 0);
            tick();
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_fill_arbiter.md
MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, legal range 1..7: cycles from a memory read address being presented to its data being valid.
REQ-002 SHALL have these ports; one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-cache miss request (block read)
- i_addr  in  16  I-side miss address; bits [3:0] ignored
- d_req  in  1  D-cache request
- d_wr  in  1  1 = single-word write-through, 0 = block read
- d_addr  in  16  D-side address
- d_wdata  in  16  D-side write data
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- fill_data  out  16  fill word, combinational copy of mem_rdata
- fill_word  out  3  index of the current fill word
- i_fill_we  out  1  write fill_data into the I-cache
- d_fill_we  out  1  write fill_data into the D-cache
- i_done  out  1  one-cycle pulse: I transaction complete
- d_done  out  1  one-cycle pulse: D transaction complete
- busy  out  1  1 when the state is not IDLE

Function
REQ-003 SHALL implement states IDLE, FILL and WRITE; req, d_wr and addresses SHALL be sampled only in IDLE.
REQ-004 IDLE, d_req=1 and d_wr=1, with D winning arbitration -> WRITE; d_req=1 and d_wr=0, with D winning -> FILL with owner D; i_req=1, with I winning -> FILL with owner I; otherwise stay in IDLE.
REQ-005 Arbitration: if only one requester is pending, grant it; if both are pending, grant the requester not served last; a last_owner flop updates at each grant.
REQ-006 FILL SHALL latch blk = addr[15:4] at grant; address input changes during FILL SHALL be ignored.
REQ-007 FILL issue phase, for 8 consecutive cycles k=0..7: mem_en=1, mem_wr=0, mem_addr = {blk, k[2:0], 1'b0}.
REQ-008 Data for issue k SHALL be captured from mem_rdata exactly LATENCY cycles after issue k, tracked by a LATENCY-deep valid shift register.
REQ-009 In each return cycle, assert the owner's fill_we, set fill_word = return count (0..7) and fill_data = mem_rdata; the non-owner's fill_we stays 0.
REQ-010 The owner's done pulse SHALL coincide with the 8th fill_we; the next state is IDLE; a fill lasts 8+LATENCY cycles.
REQ-011 WRITE SHALL last one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1, then IDLE.
REQ-012 When mem_en=0, mem_addr, mem_wdata and mem_wr SHALL be 0; fill_word SHALL be 0 when no fill_we is asserted.
REQ-013 Requesters SHALL deassert req no later than the cycle after their done pulse; a req still high in IDLE is treated as a new request.
REQ-014 A new grant SHALL NOT be made in the cycle a done pulse is asserted; the earliest next grant is the following IDLE cycle.
REQ-015 Issue and return SHALL overlap (pipelined); no mem_en cycles occur after issue 7 of a fill.

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE, clear all counters and valid bits, set last_owner=I, and drive every output to 0 (fill_data still follows mem_rdata).
REQ-017 Reset mid-FILL or mid-WRITE SHALL abandon the transaction; late memory returns after rst_n rises SHALL NOT raise any fill_we or done.

Verification
REQ-018 i_req, i_addr=0x1234, LATENCY=4 -> mem_addr 0x1230,0x1232,...,0x123E in cycles 1-8; i_fill_we in cycles 5-12 with fill_word 0..7; i_done in cycle 12; busy=0 in cycle 13.
REQ-019 After reset, i_req and d_req (read) both high -> D filled first, then I; a third tie -> D granted (last_owner=I).
REQ-020 d_req=1, d_wr=1, d_addr=0x00A4, d_wdata=0xBEEF -> one cycle with mem_en=1, mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, d_done=1; no fill_we.
REQ-021 d_req rises during an I fill -> no mem activity for D until the cycle after i_done; D issue 0 occurs 2 cycles after i_done.
REQ-022 rst_n pulsed low during the 3rd return cycle -> all outputs 0 at once; after release busy=0 and no fill_we while the memory keeps returning data.
REQ-023 i_addr changed to 0xFFF0 in fill cycle 3 -> remaining addresses stay in the originally latched block.
